// File: rtl/dtcm_xbar.sv
// -----------------------------------------------------------------------------
// dtcm_xbar
//   Request crossbar in front of the DTCM bank array. Each master issues
//   word-addressed loads/stores. The low address bits select a bank. A
//   combinational arbiter per bank picks one requester, and the bank's read
//   data returns to the winning master one cycle after the bank accepts.
//
// Build option
//   DTCM_XBAR_RR_EN : when defined, each bank arbitrates round-robin using its
//                     own pointer. When undefined, the lowest master index
//                     wins and no pointer state exists.
//
// Ports
//   clk_i, rst_ni   : clock (rising edge) and synchronous active-low reset
//   m_req_i         : [M] master request
//   m_gnt_o         : [M] request accepted this cycle
//   m_addr_i        : [M][addr_width_p] word address {in-bank addr, bank sel}
//   m_wen_i         : [M] 1 = write
//   m_wdata_i       : [M][data_width_p] write data
//   m_mask_i        : [M][mask_width_p] byte enables
//   m_rvalid_o      : [M] response (read data or write ack) for last grant
//   m_rdata_o       : [M][data_width_p] read data, zero when no response
//   b_req_o         : [B] bank request
//   b_gnt_i         : [B] bank accepts
//   b_addr_o        : [B][bank_addr_width_p] in-bank word address
//   b_wen_o         : [B] forwarded write enable
//   b_wdata_o       : [B][data_width_p] forwarded write data
//   b_mask_o        : [B][mask_width_p] forwarded byte enables
//   b_rdata_i       : [B][data_width_p] bank read data, valid one cycle
//                     after the bank accepts
// -----------------------------------------------------------------------------
module dtcm_xbar #(
  parameter int unsigned master_num_p      = 2,
  parameter int unsigned bank_num_p        = 4,
  parameter int unsigned bank_addr_width_p = 8,
  parameter int unsigned data_width_p      = 64,
  parameter int unsigned mask_width_p      = data_width_p / 8,
  parameter int unsigned sel_width_p       = $clog2(bank_num_p),
  parameter int unsigned addr_width_p      = bank_addr_width_p + sel_width_p
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,

  input  logic [master_num_p-1:0]                       m_req_i,
  output logic [master_num_p-1:0]                       m_gnt_o,
  input  logic [master_num_p-1:0][addr_width_p-1:0]     m_addr_i,
  input  logic [master_num_p-1:0]                       m_wen_i,
  input  logic [master_num_p-1:0][data_width_p-1:0]     m_wdata_i,
  input  logic [master_num_p-1:0][mask_width_p-1:0]     m_mask_i,
  output logic [master_num_p-1:0]                       m_rvalid_o,
  output logic [master_num_p-1:0][data_width_p-1:0]     m_rdata_o,

  output logic [bank_num_p-1:0]                         b_req_o,
  input  logic [bank_num_p-1:0]                         b_gnt_i,
  output logic [bank_num_p-1:0][bank_addr_width_p-1:0]  b_addr_o,
  output logic [bank_num_p-1:0]                         b_wen_o,
  output logic [bank_num_p-1:0][data_width_p-1:0]       b_wdata_o,
  output logic [bank_num_p-1:0][mask_width_p-1:0]       b_mask_o,
  input  logic [bank_num_p-1:0][data_width_p-1:0]       b_rdata_i
);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [master_num_p-1:0][sel_width_p-1:0]       w_sel;
  logic [master_num_p-1:0][bank_addr_width_p-1:0] w_baddr;
  // w_bank_req[b][m]: master m is requesting bank b (held at 0 during reset)
  logic [bank_num_p-1:0][master_num_p-1:0]        w_bank_req;
  logic [bank_num_p-1:0]                          w_bank_any;

  always_comb begin
    w_sel      = '0;
    w_baddr    = '0;
    w_bank_req = '0;
    w_bank_any = '0;
    for (int m = 0; m < int'(master_num_p); m++) begin
      w_sel[m]   = m_addr_i[m][sel_width_p-1:0];
      w_baddr[m] = m_addr_i[m][addr_width_p-1:sel_width_p];
    end
    for (int b = 0; b < int'(bank_num_p); b++) begin
      for (int m = 0; m < int'(master_num_p); m++) begin
        w_bank_req[b][m] = rst_ni & m_req_i[m] & (w_sel[m] == sel_width_p'(b));
      end
      w_bank_any[b] = |w_bank_req[b];
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bank arbitration
  // ---------------------------------------------------------------------------
  logic [bank_num_p-1:0][master_num_p-1:0] w_win_oh;

`ifdef DTCM_XBAR_RR_EN
  localparam int unsigned idx_w = (master_num_p > 1) ? $clog2(master_num_p) : 1;

  logic [bank_num_p-1:0][idx_w-1:0] r_prio;
  logic [bank_num_p-1:0][idx_w-1:0] w_win_idx;

  // Two passes replace a modulo search: first look at masters at or above the
  // pointer, then (only if none found) wrap and take the lowest requester.
  always_comb begin
    w_win_oh  = '0;
    w_win_idx = '0;
    for (int b = 0; b < int'(bank_num_p); b++) begin
      for (int m = 0; m < int'(master_num_p); m++) begin
        if (!(|w_win_oh[b]) && w_bank_req[b][m] && (m >= int'(r_prio[b]))) begin
          w_win_oh[b][m] = 1'b1;
          w_win_idx[b]   = idx_w'(m);
        end
      end
      for (int m = 0; m < int'(master_num_p); m++) begin
        if (!(|w_win_oh[b]) && w_bank_req[b][m]) begin
          w_win_oh[b][m] = 1'b1;
          w_win_idx[b]   = idx_w'(m);
        end
      end
    end
  end

  // Pointer only moves when the bank actually accepted the winner.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_prio <= '0;
    end else begin
      for (int b = 0; b < int'(bank_num_p); b++) begin
        if (w_bank_any[b] && b_gnt_i[b]) begin
          if (w_win_idx[b] == idx_w'(master_num_p - 1)) begin
            r_prio[b] <= '0;
          end else begin
            r_prio[b] <= idx_w'(w_win_idx[b] + idx_w'(1));
          end
        end
      end
    end
  end
`else
  // Fixed priority: lowest master index wins.
  always_comb begin
    w_win_oh = '0;
    for (int b = 0; b < int'(bank_num_p); b++) begin
      for (int m = 0; m < int'(master_num_p); m++) begin
        if (!(|w_win_oh[b]) && w_bank_req[b][m]) begin
          w_win_oh[b][m] = 1'b1;
        end
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Bank-side steering; banks without a request see all zeros
  // ---------------------------------------------------------------------------
  always_comb begin
    b_req_o   = w_bank_any;
    b_addr_o  = '0;
    b_wen_o   = '0;
    b_wdata_o = '0;
    b_mask_o  = '0;
    for (int b = 0; b < int'(bank_num_p); b++) begin
      for (int m = 0; m < int'(master_num_p); m++) begin
        if (w_win_oh[b][m]) begin
          b_addr_o[b]  = w_baddr[m];
          b_wen_o[b]   = m_wen_i[m];
          b_wdata_o[b] = m_wdata_i[m];
          b_mask_o[b]  = m_mask_i[m];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Master grants: winner of its bank and the bank accepted
  // ---------------------------------------------------------------------------
  always_comb begin
    m_gnt_o = '0;
    for (int b = 0; b < int'(bank_num_p); b++) begin
      for (int m = 0; m < int'(master_num_p); m++) begin
        if (w_win_oh[b][m] && b_gnt_i[b]) begin
          m_gnt_o[m] = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response tracking. Each master keeps its own bank index, so back-to-back
  // grants to different banks return the right data without cross-talk.
  // ---------------------------------------------------------------------------
  logic [master_num_p-1:0]                  r_rsp_vld;
  logic [master_num_p-1:0][sel_width_p-1:0] r_rsp_bank;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rsp_vld  <= '0;
      r_rsp_bank <= '0;
    end else begin
      r_rsp_vld <= m_gnt_o;
      for (int m = 0; m < int'(master_num_p); m++) begin
        if (m_gnt_o[m]) begin
          r_rsp_bank[m] <= w_sel[m];
        end
      end
    end
  end

  // Responses read as zero while reset is asserted, even before the first
  // reset edge has cleared the registers.
  always_comb begin
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    for (int m = 0; m < int'(master_num_p); m++) begin
      if (rst_ni && r_rsp_vld[m]) begin
        m_rvalid_o[m] = 1'b1;
        m_rdata_o[m]  = b_rdata_i[r_rsp_bank[m]];
      end
    end
  end

endmodule

// File: tb/tb_dtcm_xbar.sv
// -----------------------------------------------------------------------------
// tb_dtcm_xbar
//   Directed walk-through of the crossbar's main behaviours followed by a
//   randomized run. Every cycle is compared against a behavioural model that
//   picks bank winners by circular distance from a per-bank pointer (or by
//   lowest index when round-robin is not built in).
// -----------------------------------------------------------------------------
module tb_dtcm_xbar;

  localparam int M  = 2;
  localparam int B  = 4;
  localparam int BA = 8;
  localparam int D  = 64;
  localparam int K  = D / 8;
  localparam int S  = $clog2(B);
  localparam int A  = BA + S;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [M-1:0]         m_req, m_gnt, m_wen, m_rvalid;
  logic [M-1:0][A-1:0]  m_addr;
  logic [M-1:0][D-1:0]  m_wdata, m_rdata;
  logic [M-1:0][K-1:0]  m_mask;
  logic [B-1:0]         b_req, b_gnt, b_wen;
  logic [B-1:0][BA-1:0] b_addr;
  logic [B-1:0][D-1:0]  b_wdata, b_rdata;
  logic [B-1:0][K-1:0]  b_mask;

  always #5 clk = ~clk;

  dtcm_xbar #(
    .master_num_p      (M),
    .bank_num_p        (B),
    .bank_addr_width_p (BA),
    .data_width_p      (D)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .m_req_i    (m_req),
    .m_gnt_o    (m_gnt),
    .m_addr_i   (m_addr),
    .m_wen_i    (m_wen),
    .m_wdata_i  (m_wdata),
    .m_mask_i   (m_mask),
    .m_rvalid_o (m_rvalid),
    .m_rdata_o  (m_rdata),
    .b_req_o    (b_req),
    .b_gnt_i    (b_gnt),
    .b_addr_o   (b_addr),
    .b_wen_o    (b_wen),
    .b_wdata_o  (b_wdata),
    .b_mask_o   (b_mask),
    .b_rdata_i  (b_rdata)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int           ptr [B];
  logic [M-1:0] prv_gnt;
  int           prv_bank [M];
  // Values captured by check_now() for the model update at the next edge
  int           s_win [B];
  int           s_bank [M];
  logic [M-1:0] s_gnt;
  logic         s_rst;
  logic [B-1:0] s_bgnt;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_now();
    logic [M-1:0]         e_gnt, e_rv;
    logic [M-1:0][D-1:0]  e_rdata;
    logic [B-1:0]         e_breq, e_bwen;
    logic [B-1:0][BA-1:0] e_baddr;
    logic [B-1:0][D-1:0]  e_bwdata;
    logic [B-1:0][K-1:0]  e_bmask;
    int best, d;
    e_gnt = '0; e_rv = '0; e_rdata = '0;
    e_breq = '0; e_bwen = '0; e_baddr = '0; e_bwdata = '0; e_bmask = '0;
    for (int m = 0; m < M; m++) s_bank[m] = int'(m_addr[m] % B);
    for (int b = 0; b < B; b++) begin
      s_win[b] = -1;
      best = M;
      for (int m = 0; m < M; m++) begin
        if (rst_n && m_req[m] && s_bank[m] == b) begin
`ifdef DTCM_XBAR_RR_EN
          d = (m - ptr[b] + M) % M;
`else
          d = m;
`endif
          if (d < best) begin
            best = d;
            s_win[b] = m;
          end
        end
      end
      for (int m = 0; m < M; m++) begin
        if (s_win[b] == m) begin
          e_breq[b]   = 1'b1;
          e_baddr[b]  = BA'(m_addr[m] / B);
          e_bwen[b]   = m_wen[m];
          e_bwdata[b] = m_wdata[m];
          e_bmask[b]  = m_mask[m];
          e_gnt[m]    = b_gnt[b];
        end
      end
    end
    for (int m = 0; m < M; m++) begin
      e_rv[m] = rst_n && prv_gnt[m];
      if (e_rv[m]) begin
        for (int b = 0; b < B; b++) if (prv_bank[m] == b) e_rdata[m] = b_rdata[b];
      end
    end
    chk("m_gnt",    m_gnt,    e_gnt);
    chk("b_req",    b_req,    e_breq);
    chk("b_addr",   b_addr,   e_baddr);
    chk("b_wen",    b_wen,    e_bwen);
    chk("b_wdata",  b_wdata,  e_bwdata);
    chk("b_mask",   b_mask,   e_bmask);
    chk("m_rvalid", m_rvalid, e_rv);
    chk("m_rdata",  m_rdata,  e_rdata);
    s_gnt  = e_gnt;
    s_rst  = rst_n;
    s_bgnt = b_gnt;
  endtask

  task automatic tick();
    @(posedge clk);
    for (int b = 0; b < B; b++) begin
      if (!s_rst) ptr[b] = 0;
      else if (s_win[b] >= 0 && s_bgnt[b]) ptr[b] = (s_win[b] + 1) % M;
    end
    if (!s_rst) begin
      prv_gnt = '0;
    end else begin
      prv_gnt = s_gnt;
      for (int m = 0; m < M; m++) prv_bank[m] = s_bank[m];
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [M-1:0] exp_seq [4];
    prv_gnt = '0;
    for (int b = 0; b < B; b++) ptr[b] = 0;
    for (int m = 0; m < M; m++) prv_bank[m] = 0;
    rst_n = 1'b0; m_req = '0; m_addr = '0; m_wen = '0; m_wdata = '0; m_mask = '0;
    b_gnt = '1; b_rdata = '0;

    // Reset held, even with a request pending nothing is forwarded
    #1; check_now(); tick();
    m_req = 2'b11; m_addr[0] = 10'h001; m_addr[1] = 10'h002;
    #1; check_now(); chk("rst_gnt", m_gnt, 2'b00); chk("rst_breq", b_req, 4'b0000); tick();
    rst_n = 1'b1; m_req = '0;
    #1; check_now(); chk("rst_rvalid", m_rvalid, 2'b00); tick();

    // Single read: M0 -> addr 0x005 (bank 1, word 0x01)
    m_req = 2'b01; m_addr[0] = 10'h005; m_wen = '0; b_rdata[1] = 64'hA5;
    #1; check_now();
    chk("t1_breq", b_req, 4'b0010); chk("t1_baddr", b_addr[1], 8'h01); chk("t1_gnt", m_gnt, 2'b01);
    tick();
    m_req = '0;
    #1; check_now(); chk("t1_rvalid", m_rvalid, 2'b01); chk("t1_rdata", m_rdata[0], 64'hA5);
    tick();

    // Parallel reads on distinct banks
    m_req = 2'b11; m_addr[0] = 10'h004; m_addr[1] = 10'h007;
    b_rdata[0] = 64'h1111_0000_0000_0000; b_rdata[3] = 64'h3333;
    #1; check_now(); chk("t2_gnt", m_gnt, 2'b11); chk("t2_breq", b_req, 4'b1001); tick();
    m_req = '0;
    #1; check_now(); chk("t2_rvalid", m_rvalid, 2'b11);
    chk("t2_rdata0", m_rdata[0], 64'h1111_0000_0000_0000); chk("t2_rdata1", m_rdata[1], 64'h3333);
    tick();

    // Collision on bank 2 for four cycles
`ifdef DTCM_XBAR_RR_EN
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
`else
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01; exp_seq[3] = 2'b01;
`endif
    m_req = 2'b11; m_addr[0] = 10'h002; m_addr[1] = 10'h006;
    for (int i = 0; i < 4; i++) begin
      #1; check_now(); chk("t3_gnt", m_gnt, exp_seq[i]); tick();
    end

    // Bank 2 stalls for two cycles under the same collision
    b_gnt[2] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1; check_now(); chk("t4_stall_gnt", m_gnt, 2'b00); tick();
    end
    b_gnt[2] = 1'b1;
    #1; check_now(); chk("t4_resume_gnt", m_gnt, 2'b01); chk("t4_rvalid", m_rvalid, 2'b00); tick();

    // Write then read back at addr 0x00A (bank 2, word 0x02)
    m_req = 2'b01; m_addr[0] = 10'h00A; m_wen = 2'b01; m_wdata[0] = 64'hDEAD; m_mask[0] = 8'h03;
    #1; check_now();
    chk("t5_bwen", b_wen[2], 1'b1); chk("t5_bmask", b_mask[2], 8'h03);
    chk("t5_bwdata", b_wdata[2], 64'hDEAD); chk("t5_baddr", b_addr[2], 8'h02);
    tick();
    m_wen = '0;
    #1; check_now(); chk("t5_wack", m_rvalid, 2'b01); chk("t5_rd_gnt", m_gnt, 2'b01); tick();
    m_req = '0; b_rdata[2] = 64'hDEAD;
    #1; check_now(); chk("t5_rvalid", m_rvalid, 2'b01); chk("t5_rdata", m_rdata[0], 64'hDEAD); tick();

    // Reset lands in a cycle with a request, then a collision on bank 1
    rst_n = 1'b0; m_req = 2'b01; m_addr[0] = 10'h005;
    #1; check_now(); chk("t6_rst_gnt", m_gnt, 2'b00); chk("t6_rst_breq", b_req, 4'b0000); tick();
    rst_n = 1'b1; m_req = 2'b11; m_addr[1] = 10'h001;
    #1; check_now(); chk("t6_rvalid", m_rvalid, 2'b00); chk("t6_gnt", m_gnt, 2'b01); tick();
    m_req = '0;
    #1; check_now(); tick();

    // Randomized run; losers keep their request stable until granted
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      for (int m = 0; m < M; m++) begin
        if (!(m_req[m] && !s_gnt[m] && s_rst)) begin
          m_req[m]   = ($urandom_range(0, 3) != 0);
          m_addr[m]  = A'($urandom);
          m_wen[m]   = 1'($urandom_range(0, 1));
          m_wdata[m] = {$urandom, $urandom};
          m_mask[m]  = K'($urandom);
        end
      end
      for (int b = 0; b < B; b++) begin
        b_gnt[b]   = ($urandom_range(0, 3) != 0);
        b_rdata[b] = {$urandom, $urandom};
      end
      #1; check_now(); tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
